// File: rtl/enc4to2_rr.sv
// Registered 4-to-2 encoder with round-robin (or fixed) priority.
// Holds the granted index until acknowledged; back-to-back grants have no bubble.
module enc4to2_rr #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [0:3] Y,
    input  logic       Ack,
    output logic [1:0] W,
    output logic       En,
    output logic       Multi,
    output logic [1:0] Ptr
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned N_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] w_d, ptr_d, scan_ptr;
    logic             en_d, multi_d, capture;

    // First asserted request scanning upward from p with 2-bit wrap.
    function automatic logic [IDX_W-1:0] sel(input logic [0:N_REQ-1] y,
                                             input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] idx;
        sel = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + IDX_W'(k);
            if (y[idx]) sel = idx;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        w_d      = W;
        en_d     = En;
        multi_d  = Multi;
        ptr_d    = Ptr;
        scan_ptr = ROUND_ROBIN ? Ptr : IDX_W'(0);
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|Y) capture = 1'b1;
            end
            HOLD: begin
                if (Ack) begin
                    // The acknowledged grant moves the pointer and the same edge rescans from it.
                    if (ROUND_ROBIN) begin
                        ptr_d    = W + IDX_W'(1);
                        scan_ptr = W + IDX_W'(1);
                    end
                    if (|Y) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            w_d     = sel(Y, scan_ptr);
            en_d    = 1'b1;
            multi_d = ($countones(Y) > 1);
            state_d = HOLD;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            W       <= '0;
            En      <= 1'b0;
            Multi   <= 1'b0;
            Ptr     <= '0;
        end else begin
            state_q <= state_d;
            W       <= w_d;
            En      <= en_d;
            Multi   <= multi_d;
            Ptr     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_enc4to2_rr.sv
// Scoreboard bench for enc4to2_rr: one round-robin and one fixed-priority instance
// share stimulus; a request-level model predicts each cycle's outputs.
module tb_enc4to2_rr;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [0:3] Y;
    logic       Ack;

    logic [1:0] w_rr, ptr_rr, w_fx, ptr_fx;
    logic       en_rr, multi_rr, en_fx, multi_fx;

    enc4to2_rr #(.ROUND_ROBIN(1'b1)) u_rr (
        .Clock(Clock), .Reset(Reset), .Y(Y), .Ack(Ack),
        .W(w_rr), .En(en_rr), .Multi(multi_rr), .Ptr(ptr_rr)
    );

    enc4to2_rr #(.ROUND_ROBIN(1'b0)) u_fx (
        .Clock(Clock), .Reset(Reset), .Y(Y), .Ack(Ack),
        .W(w_fx), .En(en_fx), .Multi(multi_fx), .Ptr(ptr_fx)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit en;
        int w;
        bit multi;
        int ptr;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fx[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = fixed priority, index 1 = round robin.
    bit m_busy[2];
    int m_w[2];
    bit m_multi[2];
    int m_ptr[2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [0:3] y, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (y[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_busy[r] = 0; m_w[r] = 0; m_multi[r] = 0; m_ptr[r] = 0;
        end
    endtask

    task automatic model_step(input logic [0:3] y, input logic a);
        for (int r = 0; r < 2; r++) begin
            bit cap;
            int start;
            cap = 0;
            start = (r == 1) ? m_ptr[r] : 0;
            if (m_busy[r]) begin
                if (a) begin
                    if (r == 1) m_ptr[r] = (m_w[r] + 1) % 4;
                    start = (r == 1) ? m_ptr[r] : 0;
                    if (y != 4'b0000) cap = 1;
                    else m_busy[r] = 0;
                end
            end else if (y != 4'b0000) begin
                cap = 1;
            end
            if (cap) begin
                m_w[r]     = pick(y, start);
                m_busy[r]  = 1;
                m_multi[r] = ($countones(y) >= 2);
            end
        end
    endtask

    function automatic exp_t snap(input int r);
        exp_t e;
        e.en = m_busy[r]; e.w = m_w[r]; e.multi = m_multi[r]; e.ptr = m_ptr[r];
        return e;
    endfunction

    // Drive one cycle, predict, and queue the expected post-edge outputs.
    task automatic step(input logic [0:3] y, input logic a);
        Y = y;
        Ack = a;
        model_step(y, a);
        @(posedge Clock);
        q_fx.push_back(snap(0));
        q_rr.push_back(snap(1));
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #1 Reset = 1'b1;
        #1;
        check("rst_rr_w", int'(w_rr), 0);
        check("rst_rr_en", int'(en_rr), 0);
        check("rst_rr_multi", int'(multi_rr), 0);
        check("rst_rr_ptr", int'(ptr_rr), 0);
        check("rst_fx_en", int'(en_fx), 0);
        model_reset();
        @(negedge Clock);
        #1 Reset = 1'b0;
    endtask

    // Monitor: compare DUT outputs against queued expectations each cycle.
    always @(negedge Clock) begin
        exp_t e;
        if (q_rr.size() > 0) begin
            e = q_rr.pop_front();
            check("rr_en", int'(en_rr), int'(e.en));
            check("rr_ptr", int'(ptr_rr), e.ptr);
            if (e.en) begin
                check("rr_w", int'(w_rr), e.w);
                check("rr_multi", int'(multi_rr), int'(e.multi));
            end
        end
        if (q_fx.size() > 0) begin
            e = q_fx.pop_front();
            check("fx_en", int'(en_fx), int'(e.en));
            check("fx_ptr", int'(ptr_fx), e.ptr);
            if (e.en) begin
                check("fx_w", int'(w_fx), e.w);
                check("fx_multi", int'(multi_fx), int'(e.multi));
            end
        end
    end

    initial begin
        logic [0:3] ry;
        Reset = 1'b1;
        Y = 4'b0000;
        Ack = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        #1 Reset = 1'b0;

        // Asynchronous reset while holding W=10.
        step(4'b0010, 1'b0);
        check("pre_rst_w", int'(w_rr), 2);
        check("pre_rst_en", int'(en_rr), 1);
        do_reset();

        // Single request, held across changing Y, then released.
        step(4'b0100, 1'b0);
        check("t2_w", int'(w_rr), 1);
        check("t2_multi", int'(multi_rr), 0);
        repeat (3) step(4'b0001, 1'b0);
        check("t2_hold_w", int'(w_rr), 1);
        step(4'b0000, 1'b1);
        check("t2_en_off", int'(en_rr), 0);
        check("t2_ptr", int'(ptr_rr), 2);

        // All requests held with continuous Ack: rotation and fixed priority.
        do_reset();
        step(4'b1111, 1'b0);
        repeat (5) step(4'b1111, 1'b1);
        do_reset();
        repeat (6) step(4'b0110, 1'b1);
        check("t4_fx_w", int'(w_fx), 1);
        check("t4_fx_ptr", int'(ptr_fx), 0);

        // Pointer at 3 with Y=1001, then wrap to 0.
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b1001, 1'b0);
        check("t5_w", int'(w_rr), 3);
        step(4'b0000, 1'b1);
        check("t5_ptr", int'(ptr_rr), 0);
        step(4'b1001, 1'b0);
        check("t5_w2", int'(w_rr), 0);
        step(4'b0000, 1'b1);

        // Ack while idle is ignored.
        repeat (5) step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        check("t6_w", int'(w_rr), 2);
        check("t6_en", int'(en_rr), 1);

        // Random traffic with an occasional reset.
        for (int n = 0; n < 600; n++) begin
            ry = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(1, 15));
            step(ry, 1'($urandom_range(0, 1)));
            if (n == 300) do_reset();
        end

        for (int k = 0; k < 4 && (q_rr.size() > 0 || q_fx.size() > 0); k++)
            @(negedge Clock);
        #1;
        check("queue_drained", q_rr.size() + q_fx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc4to2_rr.md
Name: enc4to2_rr

Overview:
- Registered 4-to-2 encoder with round-robin priority: the reverse of the team's 2-to-4 one-hot decoder.
- Samples a 4-bit request vector Y[0:3] and picks one asserted bit. It outputs that bit's 2-bit index W with a valid flag En, and holds the result until the consumer acknowledges.
- Bit ordering matches the decoder: Y[0] maps to W=00 and Y[3] maps to W=11. Decoding a granted W with En=1 reproduces a one-hot of the granted bit.
- Sits in front of request sources that share one decoder-selected resource.

Parameters:
- ROUND_ROBIN, 1, 1 = rotating priority starting at the pointer; 0 = fixed priority with Y[0] highest and the pointer ignored.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Y  input  [0:3]  request lines; Y[i] requests code i
- Ack  input  1  consumer accepts the current W; meaningful only while En=1
- W  output  [1:0]  encoded index of the granted request (registered)
- En  output  1  W is valid (registered)
- Multi  output  1  more than one Y bit was set when W was captured (registered)
- Ptr  output  [1:0]  current round-robin start index (debug, registered)

Behaviour:
- Reset (asynchronous, Reset=1): state=IDLE, W=00, En=0, Multi=0, Ptr=00. Takes effect immediately, including mid-HOLD; any pending grant is dropped.
- States: IDLE (En=0) and HOLD (En=1).
- Selection function sel(Y,P):
  - Scan indices P, P+1, P+2, P+3, modulo 4 (2-bit wrap, so 3+1=0).
  - The first index with Y[i]=1 wins.
  - When ROUND_ROBIN=0, P is treated as 00.
- Capture at a rising edge:
  - W <= sel(Y,Ptr)
  - En <= 1
  - Multi <= (popcount(Y) >= 2)
  - state <= HOLD
- IDLE:
  - If Y != 0000 at the edge: capture. Latency is one cycle from Y sampled to En=1.
  - If Y == 0000: stay in IDLE. W and Multi hold their last values; they are don't-care while En=0.
- HOLD:
  - Y is ignored.
  - W, En and Multi are stable until an edge with Ack=1.
- HOLD with Ack=1 at an edge:
  - Ptr <= W+1 (mod 4) when ROUND_ROBIN=1; Ptr stays 00 when ROUND_ROBIN=0.
  - Back-to-back: Y is evaluated in the same edge using the new pointer value (W+1). If Y != 0000, capture immediately and stay in HOLD, so En remains 1 with a new W and no bubble.
  - If Y == 0000: En <= 0 and state <= IDLE.
- Ack while En=0: ignored, no state change.
- Ptr changes only on an acknowledged grant. Requests that are dropped before they are granted do not move the pointer.
- A request must stay asserted to be served; nothing is queued beyond the single HOLD register.
- Y is assumed synchronous to Clock; no input synchronizers.
- Implementation: one sequential always block for state, W, En, Multi and Ptr; combinational sel() logic.

Test Plan:
1. Reset=1 mid-HOLD (W=10, En=1) -> W=00, En=0, Multi=0, Ptr=00 immediately, with no clock edge needed.
2. From reset, Y=0100 for one edge -> next cycle W=01, En=1, Multi=0. With Ack=0 for 3 cycles and Y changed to 0001, W stays 01. Ack=1 with Y=0000 -> En=0, Ptr=10.
3. ROUND_ROBIN=1, Y=1111 held, Ack=1 every cycle -> W sequence 00,01,10,11,00 with En continuously 1, Multi=1 throughout, Ptr wrapping 01,10,11,00.
4. ROUND_ROBIN=0, Y=0110 held, Ack=1 every cycle -> W=01 every grant, Multi=1, Ptr stays 00.
5. Ptr=11, Y=1001 -> W=11 (the scan starts at 3). After Ack, Ptr=00 and the next grant is W=00.
6. IDLE with Ack=1 and Y=0000 for 5 cycles -> En stays 0 and Ptr is unchanged. Then Y=0010 -> W=10, En=1 one cycle later.
